// File: rtl/pwm_gen.sv
// Programmable PWM generator: high time and period in clk cycles, double-buffered
// configuration that only takes effect in IDLE or on a period boundary.
module pwm_gen #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] cfg_high,
   input  logic [WIDTH-1:0] cfg_T,
   output logic             sig,
   output logic             period_tick,
   output logic             busy,
   output logic [WIDTH-1:0] periods
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] p_high_q, p_T_q, a_high_q, a_T_q, cnt_q, periods_q;
   logic             pend_q, sig_q, tick_q, busy_q;

   logic [WIDTH-1:0] eff_high_d, eff_T_d;
   logic             bound_d, apply_d;

   // Effective config is what will be active once any pending pair is applied.
   always_comb begin
      eff_high_d = pend_q ? p_high_q : a_high_q;
      eff_T_d    = pend_q ? p_T_q    : a_T_q;
      bound_d    = (state_q == RUN) && (cnt_q == a_T_q - WIDTH'(1));
      apply_d    = pend_q && ((state_q == IDLE) || bound_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         p_high_q  <= '0;
         p_T_q     <= '0;
         pend_q    <= 1'b0;
         a_high_q  <= '0;
         a_T_q     <= '0;
         cnt_q     <= '0;
         sig_q     <= 1'b0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
         periods_q <= '0;
      end else begin
         if (apply_d) begin
            a_high_q <= p_high_q;
            a_T_q    <= p_T_q;
         end
         // A load coinciding with an apply stays pending for the next boundary.
         if (load) begin
            p_high_q <= cfg_high;
            p_T_q    <= cfg_T;
            pend_q   <= 1'b1;
         end else if (apply_d) begin
            pend_q   <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               cnt_q  <= '0;
               sig_q  <= 1'b0;
               tick_q <= 1'b0;
               busy_q <= 1'b0;
               if (en && (eff_T_d != '0)) begin
                  state_q   <= RUN;
                  busy_q    <= 1'b1;
                  tick_q    <= 1'b1;
                  sig_q     <= (eff_high_d != '0);
                  periods_q <= periods_q + WIDTH'(1);
               end
            end
            RUN: begin
               if (bound_d) begin
                  cnt_q <= '0;
                  if (!en || (eff_T_d == '0)) begin
                     state_q <= IDLE;
                     sig_q   <= 1'b0;
                     tick_q  <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     tick_q    <= 1'b1;
                     sig_q     <= (eff_high_d != '0);
                     periods_q <= periods_q + WIDTH'(1);
                  end
               end else begin
                  cnt_q  <= cnt_q + WIDTH'(1);
                  tick_q <= 1'b0;
                  sig_q  <= ((cnt_q + WIDTH'(1)) < a_high_q);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sig         = sig_q;
   assign period_tick = tick_q;
   assign busy        = busy_q;
   assign periods     = periods_q;

endmodule
